// File: rtl/tracking_axil_regslave.sv
// AXI4-Lite register slave: four RW registers (0x00..0x0C) plus the read-only tracking status word (0x10).
// Latency: a write commits on its final AW/W handshake, BVALID follows one cycle later; RVALID follows AR by one cycle.
// Backpressure: BVALID/RVALID hold until BREADY/RREADY; no new AW/W or AR is taken while a response is pending.
// Optional: define TRACKING_AXIL_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module tracking_axil_regslave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_i,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
   output logic [3:0]                      wr_pulse_o
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int NB = DW / 8;

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef TRACKING_AXIL_SLVERR_EN
   localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t         wstate;
   rstate_t         rstate;
   logic [DW-1:0]   regs [4];
   logic [AW-1:0]   awaddr_q;
   logic [DW-1:0]   wdata_q;
   logic [NB-1:0]   wstrb_q;

   logic            aw_hs, w_hs, ar_hs, commit;
   logic [AW-1:0]   c_addr;
   logic [DW-1:0]   c_data;
   logic [NB-1:0]   c_strb;
   logic [2:0]      c_idx;
   logic [1:0]      c_resp;
   logic [2:0]      r_idx;
   logic [DW-1:0]   rd_data;
   logic [1:0]      rd_resp;

   // Address LSBs select bytes within a word and the PROT fields carry nothing this slave uses.
   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, c_addr[1:0], S_AXI_ARADDR[1:0]};

   assign reg0_o = regs[0];
   assign reg1_o = regs[1];
   assign reg2_o = regs[2];
   assign reg3_o = regs[3];

   assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

   function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [NB-1:0] strb);
      logic [DW-1:0] res;
      res = old_v;
      for (int b = 0; b < NB; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   // Commit detection: combine the live channel with whichever half was latched earlier.
   always_comb begin
      commit = 1'b0;
      c_addr = S_AXI_AWADDR;
      c_data = S_AXI_WDATA;
      c_strb = S_AXI_WSTRB;
      case (wstate)
         W_IDLE:    commit = aw_hs & w_hs;
         W_HAVE_AW: begin
            commit = w_hs;
            c_addr = awaddr_q;
         end
         W_HAVE_W:  begin
            commit = aw_hs;
            c_data = wdata_q;
            c_strb = wstrb_q;
         end
         default:   commit = 1'b0;
      endcase
      c_idx  = c_addr[4:2];
      c_resp = (c_idx <= 3'd4) ? RESP_OKAY : RESP_UNMAPPED;
      wr_pulse_o = 4'b0000;
      // A reset at this edge abandons the write, so the strobe must not fire either.
      if (commit && !ARESET && !c_idx[2]) wr_pulse_o[c_idx[1:0]] = 1'b1;
   end

   // Register file: byte-masked update on commit, status slot and unmapped slots never stored.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (commit && !c_idx[2]) begin
         regs[c_idx[1:0]] <= merge_bytes(regs[c_idx[1:0]], c_data, c_strb);
      end
   end

   // Write channel FSM with registered READY/BVALID/BRESP.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wstate        <= W_IDLE;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= 2'b00;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (commit) begin
                  S_AXI_AWREADY <= 1'b0;
                  S_AXI_WREADY  <= 1'b0;
                  S_AXI_BVALID  <= 1'b1;
                  S_AXI_BRESP   <= c_resp;
                  wstate        <= W_RESP;
               end else if (aw_hs) begin
                  awaddr_q      <= S_AXI_AWADDR;
                  S_AXI_AWREADY <= 1'b0;
                  S_AXI_WREADY  <= 1'b1;
                  wstate        <= W_HAVE_AW;
               end else if (w_hs) begin
                  wdata_q       <= S_AXI_WDATA;
                  wstrb_q       <= S_AXI_WSTRB;
                  S_AXI_AWREADY <= 1'b1;
                  S_AXI_WREADY  <= 1'b0;
                  wstate        <= W_HAVE_W;
               end else begin
                  S_AXI_AWREADY <= 1'b1;
                  S_AXI_WREADY  <= 1'b1;
               end
            end
            W_HAVE_AW: begin
               if (commit) begin
                  S_AXI_WREADY <= 1'b0;
                  S_AXI_BVALID <= 1'b1;
                  S_AXI_BRESP  <= c_resp;
                  wstate       <= W_RESP;
               end
            end
            W_HAVE_W: begin
               if (commit) begin
                  S_AXI_AWREADY <= 1'b0;
                  S_AXI_BVALID  <= 1'b1;
                  S_AXI_BRESP   <= c_resp;
                  wstate        <= W_RESP;
               end
            end
            W_RESP: begin
               if (S_AXI_BVALID && S_AXI_BREADY) begin
                  S_AXI_BVALID  <= 1'b0;
                  S_AXI_AWREADY <= 1'b1;
                  S_AXI_WREADY  <= 1'b1;
                  wstate        <= W_IDLE;
               end
            end
         endcase
      end
   end

   // Read data select, evaluated against the registers as they stand before any same-cycle commit.
   always_comb begin
      r_idx   = S_AXI_ARADDR[4:2];
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (r_idx)
         3'd0:    rd_data = regs[0];
         3'd1:    rd_data = regs[1];
         3'd2:    rd_data = regs[2];
         3'd3:    rd_data = regs[3];
         3'd4:    rd_data = status_i;
         default: rd_resp = RESP_UNMAPPED;
      endcase
   end

   // Read channel FSM: capture data on AR handshake, hold it until RREADY.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rstate        <= R_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RRESP   <= 2'b00;
         S_AXI_RDATA   <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (ar_hs) begin
                  S_AXI_RDATA   <= rd_data;
                  S_AXI_RRESP   <= rd_resp;
                  S_AXI_RVALID  <= 1'b1;
                  S_AXI_ARREADY <= 1'b0;
                  rstate        <= R_DATA;
               end else begin
                  S_AXI_ARREADY <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RVALID && S_AXI_RREADY) begin
                  S_AXI_RVALID  <= 1'b0;
                  S_AXI_ARREADY <= 1'b1;
                  rstate        <= R_IDLE;
               end
            end
         endcase
      end
   end

endmodule
